// File: rtl/serial_link_pkg.sv
// Shared constants and state encoding for the 11-bit serial link.
package serial_link_pkg;

    localparam int unsigned N     = 11;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_t;

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in/serial-out shift register, MSB first, zero fill.
module piso_shreg #(
    parameter int unsigned N = serial_link_pkg::N
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         sclr,
    input  logic         load,
    input  logic         shift_s,
    input  logic [N-1:0] data_in,
    output logic         msb
);

    logic [N-1:0] sreg;

    // Clear dominates load, load dominates shift.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sreg <= '0;
        end else if (sclr) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= data_in;
        end else if (shift_s) begin
            sreg <= {sreg[N-2:0], 1'b0};
        end
    end

    assign msb = sreg[N-1];

endmodule

// File: rtl/serializer_11bit_msb_first.sv
// Serial link transmitter: accepts a word on start/ready, shifts it out MSB first
// with consumer backpressure, then pulses done for one cycle.
module serializer_11bit_msb_first
    import serial_link_pkg::*;
(
    input  logic         clk,
    input  logic         clr_n,
    input  logic         sclr,
    input  logic [N-1:0] data_in,
    input  logic         start,
    output logic         ready,
    output logic         ser_out,
    output logic         ser_valid,
    input  logic         ser_en,
    output logic         busy,
    output logic         done
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             shift_s;
    logic             msb;

    assign load    = (state == StIdle) && start;
    assign shift_s = (state == StShift) && ser_en;

    piso_shreg #(
        .N(N)
    ) u_shreg (
        .clk     (clk),
        .clr_n   (clr_n),
        .sclr    (sclr),
        .load    (load),
        .shift_s (shift_s),
        .data_in (data_in),
        .msb     (msb)
    );

    // FSM and bit counter; cnt holds the number of bits still to transfer.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= StIdle;
            cnt   <= '0;
        end else if (sclr) begin
            state <= StIdle;
            cnt   <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        state <= StShift;
                        cnt   <= CNT_W'(N);
                    end
                end
                StShift: begin
                    if (ser_en) begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= StDone;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Output decode from registered state and shift-register MSB.
    always_comb begin
        ready     = (state == StIdle);
        ser_valid = (state == StShift);
        done      = (state == StDone);
        busy      = (state != StIdle);
        ser_out   = (state == StShift) ? msb : 1'b0;
    end

endmodule

// File: tb/tb_serializer_11bit_msb_first.sv
// Self-checking bench: behavioural model of the transmitter plus directed scenarios.
module tb_serializer_11bit_msb_first;

    logic        clk;
    logic        clr_n;
    logic        sclr;
    logic [10:0] data_in;
    logic        start;
    logic        ready;
    logic        ser_out;
    logic        ser_valid;
    logic        ser_en;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    serializer_11bit_msb_first dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .sclr      (sclr),
        .data_in   (data_in),
        .start     (start),
        .ready     (ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_en    (ser_en),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: bits left to send, the word in flight, and a done-pending flag.
    int          m_rem   = 0;
    logic [10:0] m_word  = '0;
    bit          m_dflag = 1'b0;

    // Loopback receiver and event counters.
    logic [10:0] rx = '0;
    int          xfers = 0;
    int          done_cnt = 0;

    always @(posedge clk) begin
        if (ser_valid && ser_en) begin
            rx    <= {rx[9:0], ser_out};
            xfers <= xfers + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    always @(negedge clr_n) begin
        m_rem   = 0;
        m_dflag = 1'b0;
    end

    // Advance the model on each edge, then compare all outputs just after the edge.
    always @(posedge clk) begin
        if (!clr_n || sclr) begin
            m_rem   = 0;
            m_dflag = 1'b0;
        end else if (m_dflag) begin
            m_dflag = 1'b0;
        end else if (m_rem > 0) begin
            if (ser_en) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) m_dflag = 1'b1;
            end
        end else if (start) begin
            m_word = data_in;
            m_rem  = 11;
        end
        #1;
        chk("ready", ready, (m_rem == 0 && !m_dflag));
        chk("ser_valid", ser_valid, (m_rem > 0));
        chk("ser_out", ser_out, (m_rem > 0) ? m_word[m_rem-1] : 1'b0);
        chk("busy", busy, (m_rem > 0 || m_dflag));
        chk("done", done, m_dflag);
        if (m_dflag) chk("rx_word", rx, m_word);
    end

    // mode 0: ser_en high; 1: toggling; 2: random; 3: high with a stray start mid-word.
    task automatic send_word(input logic [10:0] w, input int mode);
        int  x0;
        int  d0;
        bit  seen;
        x0   = xfers;
        d0   = done_cnt;
        seen = 1'b0;
        @(negedge clk);
        data_in = w;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        data_in = 11'($urandom);
        for (int cyc = 0; cyc < 200; cyc++) begin
            case (mode)
                1:       ser_en = (cyc % 2 == 0);
                2:       ser_en = ($urandom_range(0, 2) != 0);
                default: ser_en = 1'b1;
            endcase
            if (mode == 3 && cyc == 4) begin
                start   = 1'b1;
                data_in = 11'h000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk("done_seen", seen, 1'b1);
        @(negedge clk);
        chk("xfer_count", xfers - x0, 11);
        chk("done_once", done_cnt - d0, 1);
        chk("rx_loopback", rx, w);
        chk("ready_after", ready, 1'b1);
    endtask

    initial begin
        logic [10:0] pat;
        int          d0;
        clr_n   = 1'b0;
        sclr    = 1'b0;
        start   = 1'b0;
        data_in = '0;
        ser_en  = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", ser_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ser_out", ser_out, 1'b0);
        clr_n = 1'b1;
        repeat (2) @(negedge clk);

        // Literal MSB-first sequence and latency
        pat     = 11'h596;
        data_in = pat;
        start   = 1'b1;
        ser_en  = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                start   = 1'b0;
                data_in = '0;
            end
            chk("t2_bit", ser_out, pat[10-i]);
            chk("t2_valid", ser_valid, 1'b1);
        end
        @(posedge clk);
        #1;
        chk("t2_done", done, 1'b1);
        chk("t2_valid_off", ser_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("t2_ready", ready, 1'b1);
        chk("t2_done_off", done, 1'b0);
        chk("t2_rx", rx, 11'h596);

        // Backpressure
        send_word(11'h7FF, 1);
        // Stray start mid-word is ignored
        send_word(11'h123, 3);

        // Synchronous clear after the 5th bit
        d0 = done_cnt;
        @(negedge clk);
        data_in = 11'h2AA;
        start   = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        ser_en = 1'b1;
        repeat (5) @(negedge clk);
        sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        chk("sclr_ready", ready, 1'b1);
        chk("sclr_busy", busy, 1'b0);
        chk("sclr_done", done, 1'b0);
        repeat (3) @(negedge clk);
        chk("sclr_no_done", done_cnt - d0, 0);
        send_word(11'h001, 0);

        // Randomised traffic including stray starts and occasional clears
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start   = ($urandom_range(0, 3) == 0);
            data_in = 11'($urandom);
            ser_en  = ($urandom_range(0, 3) != 0);
            sclr    = ($urandom_range(0, 60) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        sclr  = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        for (int i = 0; i < 6; i++) send_word(11'($urandom), 2);

        // Asynchronous reset mid-word
        @(negedge clk);
        data_in = 11'h5A5;
        start   = 1'b1;
        ser_en  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3;
        clr_n = 1'b0;
        #1;
        chk("arst_ready", ready, 1'b1);
        chk("arst_valid", ser_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ser_out", ser_out, 1'b0);
        chk("arst_done", done, 1'b0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        send_word(11'h3C3, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
